// File: rtl/oct_entry_to_bin.sv
// Front-panel octal operand entry: debounced buttons push up to three octal digits,
// which are committed as an 8-bit binary operand.
module oct_entry_to_bin #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_digit_sw,
  input  logic       i_btn_digit,
  input  logic       i_btn_back,
  input  logic       i_btn_clear,
  input  logic       i_btn_enter,
  output logic [8:0] o_entry_digits,
  output logic [1:0] o_digit_count,
  output logic       o_overflow,
  output logic [7:0] o_result,
  output logic       o_result_valid,
  output logic       o_err
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_FULL, S_DONE} state_t;

  // Button index: 0 digit, 1 back, 2 enter, 3 clear
  logic [3:0] w_btn_raw;
  logic [3:0] w_rise;

  assign w_btn_raw = {i_btn_clear, i_btn_enter, i_btn_back, i_btn_digit};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic          r_sync1;
      logic          r_sync2;
      logic          r_deb;
      logic          r_deb_d;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
          r_deb_d <= r_deb;
          // Level is accepted only after DEB_CYCLES consecutive disagreeing samples
          if (r_sync2 != r_deb) begin
            if (r_cnt == CW'(DEB_CYCLES - 1)) begin
              r_deb <= r_sync2;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_rise[gi] = r_deb & ~r_deb_d;
    end
  endgenerate

  state_t     r_state, w_state_next;
  logic [8:0] r_entry, w_entry_next;
  logic [1:0] r_count, w_count_next;
  logic [7:0] r_result, w_result_next;
  logic       r_valid, w_valid_next;
  logic       r_err, w_err_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_EMPTY;
      r_entry  <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_entry  <= w_entry_next;
      r_count  <= w_count_next;
      r_result <= w_result_next;
      r_valid  <= w_valid_next;
      r_err    <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_entry_next  = r_entry;
    w_count_next  = r_count;
    w_result_next = r_result;
    w_valid_next  = 1'b0;
    w_err_next    = 1'b0;
    // Priority chain drops lower-priority edges arriving in the same cycle
    if (w_rise[3]) begin
      w_entry_next = '0;
      w_count_next = '0;
      w_state_next = S_EMPTY;
    end else if (w_rise[2]) begin
      if (r_state != S_DONE && r_count != 2'd0) begin
        if (r_entry[8]) begin
          w_err_next = 1'b1;
        end else begin
          w_result_next = r_entry[7:0];
          w_valid_next  = 1'b1;
          w_state_next  = S_DONE;
        end
      end
    end else if (w_rise[1]) begin
      if (r_state == S_ENTRY || r_state == S_FULL) begin
        w_entry_next = {3'b000, r_entry[8:3]};
        w_count_next = r_count - 2'd1;
        w_state_next = (r_count == 2'd1) ? S_EMPTY : S_ENTRY;
      end
    end else if (w_rise[0]) begin
      if (r_state == S_FULL) begin
        w_err_next = 1'b1;
      end else if (r_state == S_DONE) begin
        w_entry_next = {6'b0, i_digit_sw};
        w_count_next = 2'd1;
        w_state_next = S_ENTRY;
      end else begin
        w_entry_next = {r_entry[5:0], i_digit_sw};
        w_count_next = r_count + 2'd1;
        w_state_next = (r_count == 2'd2) ? S_FULL : S_ENTRY;
      end
    end
  end

  assign o_entry_digits = r_entry;
  assign o_digit_count  = r_count;
  assign o_overflow     = r_entry[8];
  assign o_result       = r_result;
  assign o_result_valid = r_valid;
  assign o_err          = r_err;

endmodule

// File: tb/tb_oct_entry_to_bin.sv
// Bench for oct_entry_to_bin: directed front-panel scenarios plus random presses,
// checked against a digit-queue model of the entry.
module tb_oct_entry_to_bin;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] digit_sw;
  logic       btn_digit, btn_back, btn_clear, btn_enter;
  logic [8:0] entry_digits;
  logic [1:0] digit_count;
  logic       overflow;
  logic [7:0] result;
  logic       result_valid;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: typed digits, most significant first
  int q[$];
  bit m_done;
  int m_result;
  int m_valid;
  int m_err;

  oct_entry_to_bin #(.DEB_CYCLES(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_digit_sw     (digit_sw),
    .i_btn_digit    (btn_digit),
    .i_btn_back     (btn_back),
    .i_btn_clear    (btn_clear),
    .i_btn_enter    (btn_enter),
    .o_entry_digits (entry_digits),
    .o_digit_count  (digit_count),
    .o_overflow     (overflow),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_value();
    int v = 0;
    foreach (q[i]) v = v * 8 + q[i];
    return v;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_done   = 1'b0;
    m_result = 0;
  endfunction

  // mask bits: 3 clear, 2 enter, 1 back, 0 digit
  function automatic void m_apply(input logic [3:0] mask, input int sw);
    m_valid = 0;
    m_err   = 0;
    if (mask[3]) begin
      q.delete();
      m_done = 1'b0;
    end else if (mask[2]) begin
      if (q.size() != 0 && !m_done) begin
        if (m_value() > 255) m_err = 1;
        else begin
          m_result = m_value();
          m_valid  = 1;
          m_done   = 1'b1;
        end
      end
    end else if (mask[1]) begin
      if (q.size() != 0 && !m_done) void'(q.pop_back());
    end else if (mask[0]) begin
      if (m_done) begin
        q.delete();
        q.push_back(sw);
        m_done = 1'b0;
      end else if (q.size() == 3) m_err = 1;
      else q.push_back(sw);
    end
  endfunction

  task automatic check_state();
    check_value("entry_digits", int'(entry_digits), m_value());
    check_value("digit_count", int'(digit_count), q.size());
    check_value("overflow", int'(overflow), (m_value() > 255) ? 1 : 0);
    check_value("result", int'(result), m_result);
  endtask

  // Hold the buttons in mask for 'hold' cycles, release for 12, tally output pulses.
  task automatic press(input logic [3:0] mask, input int sw, input int hold, input bit takes);
    int nv = 0, ne = 0, nb = 0;
    digit_sw = 3'(sw);
    {btn_clear, btn_enter, btn_back, btn_digit} = mask;
    repeat (hold) begin
      @(negedge clk);
      nv += int'(result_valid);
      ne += int'(err);
      nb += int'(result_valid & err);
    end
    {btn_clear, btn_enter, btn_back, btn_digit} = 4'b0000;
    repeat (12) begin
      @(negedge clk);
      nv += int'(result_valid);
      ne += int'(err);
      nb += int'(result_valid & err);
    end
    if (takes) m_apply(mask, sw);
    else begin
      m_valid = 0;
      m_err   = 0;
    end
    $display("press mask=%b sw=%0d hold=%0d entry=%o count=%0d result=%0d valid_pulses=%0d err_pulses=%0d",
             mask, sw, hold, entry_digits, digit_count, result, nv, ne);
    check_value("valid_pulses", nv, m_valid);
    check_value("err_pulses", ne, m_err);
    check_value("pulse_overlap", nb, 0);
    check_state();
  endtask

  task automatic dig(input int sw);
    press(4'b0001, sw, 10, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_entry"}, int'(entry_digits), 0);
    check_value({tag, "_count"}, int'(digit_count), 0);
    check_value({tag, "_overflow"}, int'(overflow), 0);
    check_value({tag, "_result"}, int'(result), 0);
    check_value({tag, "_valid"}, int'(result_valid), 0);
    check_value({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    digit_sw = 3'd0;
    {btn_clear, btn_enter, btn_back, btn_digit} = 4'b0000;
    m_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3,7,7 then enter
    dig(3); dig(7); dig(7);
    check_value("entry_377", int'(entry_digits), 9'o377);
    press(4'b0100, 0, 10, 1'b1);
    check_value("result_ff", int'(result), 8'hFF);
    check_value("count_after_commit", int'(digit_count), 3);

    // 4,0,0 overflows; enter rejected; back twice; enter commits 4
    dig(4); dig(0); dig(0);
    check_value("overflow_400", int'(overflow), 1);
    press(4'b0100, 0, 10, 1'b1);
    press(4'b0010, 0, 10, 1'b1);
    press(4'b0010, 0, 10, 1'b1);
    check_value("entry_004", int'(entry_digits), 9'o004);
    press(4'b0100, 0, 10, 1'b1);
    check_value("result_04", int'(result), 8'h04);

    // Fourth digit rejected, then clear
    dig(1); dig(2); dig(3); dig(5);
    check_value("entry_123", int'(entry_digits), 9'o123);
    press(4'b1000, 0, 10, 1'b1);

    // Glitch ignored, long hold pushes once
    press(4'b0001, 6, 2, 1'b0);
    press(4'b0001, 6, 50, 1'b1);

    // Clear and digit together: clear wins
    press(4'b1001, 2, 10, 1'b1);
    check_value("clear_wins_count", int'(digit_count), 0);

    // After commit, a digit starts a new entry
    dig(1); press(4'b0100, 0, 10, 1'b1);
    dig(6);
    check_value("entry_006", int'(entry_digits), 9'o006);
    check_value("count_006", int'(digit_count), 1);

    // Reset mid-entry
    dig(2); dig(5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    press(4'b0100, 0, 10, 1'b1);

    // Random presses
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [3:0] mask;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: mask = 4'b0001;
        5:             mask = 4'b0010;
        6:             mask = 4'b0100;
        7:             mask = 4'b1000;
        default:       mask = 4'($urandom_range(1, 15));
      endcase
      press(mask, $urandom_range(0, 7), $urandom_range(8, 14), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
